// File: rtl/dmem_latency_model.sv
// dmem_latency_model: behavioural data memory behind the load/store queue.
// A 1024-word backing store, a direct-mapped tag model (16 lines x 4 words)
// that sets hit/miss latency, an in-order outstanding-request FIFO of DEPTH
// slots, and back-pressure through stall_out while that FIFO is full.
module dmem_latency_model #(
  parameter int DEPTH    = 4,
  parameter int HIT_LAT  = 2,
  parameter int MISS_LAT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        rw_in,
  input  logic [3:0]  id_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // A slot's countdown starts at latency-1 so that it reaches zero one edge
  // before the edge that pops it.
  localparam logic [3:0]    HIT_CNT  = 4'(HIT_LAT - 1);
  localparam logic [3:0]    MISS_CNT = 4'(MISS_LAT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Ring-pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Backing store and tag model
  logic [31:0] mem      [1024];
  logic [15:0] line_vld;
  logic [3:0]  line_tag [16];

  // Outstanding-request FIFO
  logic [3:0]       slot_id   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [3:0]       slot_cnt  [DEPTH];
  logic [DEPTH-1:0] slot_occ;
  logic [DEPTH-1:0] slot_occ_nxt;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  // Request decode at the accepting edge
  logic [9:0]  word_idx;
  logic [3:0]  line_idx;
  logic [3:0]  req_tag;
  logic        accept_p0;
  logic        hit_p0;
  logic        pop_p0;
  logic [3:0]  init_cnt_p0;
  logic [31:0] slot_wdata_p0;

  // Address bits outside the 4 KiB word window carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_in[31:12], addr_in[1:0]};

  assign word_idx = addr_in[11:2];
  assign line_idx = addr_in[7:4];
  assign req_tag  = addr_in[11:8];

  // Full is decoded from registered occupancy only, so an edge that pops a
  // full FIFO still refuses the request presented at that same edge.
  assign stall_out = (count == FULL_CNT);
  assign accept_p0 = valid_in && !stall_out;

  assign hit_p0      = line_vld[line_idx] && (line_tag[line_idx] == req_tag);
  assign init_cnt_p0 = hit_p0 ? HIT_CNT : MISS_CNT;

  // Loads capture the word as it stands before this edge, which already
  // includes every store accepted at an earlier edge; stores echo data_in.
  assign slot_wdata_p0 = rw_in ? data_in : mem[word_idx];

  // Only the head may complete; younger slots that are ready wait behind it.
  assign pop_p0 = slot_occ[head] && (slot_cnt[head] == 4'd0);

  // Next occupancy map and count from this edge's accept and pop.
  always_comb begin
    slot_occ_nxt = slot_occ;
    if (pop_p0) begin
      slot_occ_nxt[head] = 1'b0;
    end
    if (accept_p0) begin
      slot_occ_nxt[tail] = 1'b1;
    end
    count_nxt = count;
    case ({accept_p0, pop_p0})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Backing store write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept_p0 && rw_in) begin
      mem[word_idx] <= data_in;
    end
  end

  // Line valid bits: cleared by reset, set on any accepted access (allocate on miss).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_vld <= '0;
    end else if (accept_p0) begin
      line_vld[line_idx] <= 1'b1;
    end
  end

  // Line tags: rewritten on a miss; meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (accept_p0 && !hit_p0) begin
      line_tag[line_idx] <= req_tag;
    end
  end

  // Slot payload: load on push, otherwise count occupied slots down to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept_p0 && (tail == PW'(i))) begin
        slot_id[i]   <= id_in;
        slot_data[i] <= slot_wdata_p0;
        slot_cnt[i]  <= init_cnt_p0;
      end else if (slot_occ[i] && (slot_cnt[i] != 4'd0)) begin
        slot_cnt[i] <= slot_cnt[i] - 4'd1;
      end
    end
  end

  // FIFO control state: pointers, occupancy map and count; reset drops in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      slot_occ <= '0;
    end else begin
      if (pop_p0) begin
        head <= ptr_inc(head);
      end
      if (accept_p0) begin
        tail <= ptr_inc(tail);
      end
      count    <= count_nxt;
      slot_occ <= slot_occ_nxt;
    end
  end

  // Completion register: one-cycle ready pulse; id/data hold between pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_out <= 1'b0;
      id_out    <= '0;
      data_out  <= '0;
    end else begin
      ready_out <= pop_p0;
      if (pop_p0) begin
        id_out   <= slot_id[head];
        data_out <= slot_data[head];
      end
    end
  end

endmodule

// File: doc/dmem_latency_model.md
# dmem_latency_model

Behavioural data-memory system sitting directly downstream of the load/store queue, consuming its `addr/data/rw/id/valid` request stream and returning tagged completions. It replaces the fixed two-cycle data-cache stub with a 1024-word backing store, a direct-mapped tag model that yields hit/miss latencies, a bounded in-order outstanding-request buffer and a real `stall_out` back-pressure signal.

## Interface
- `DEPTH`, 4: outstanding-request slots (2..8).
- `HIT_LAT`, 2: edges from accept to response on tag hit (1..15).
- `MISS_LAT`, 6: edges from accept to response on tag miss (HIT_LAT..15).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `addr_in` input 32: byte address; word index `addr_in[11:2]`, bits above 11 ignored.
- `data_in` input 32: store data.
- `rw_in` input 1: 1 = store, 0 = load.
- `id_in` input 4: LSQ entry id, returned unchanged.
- `valid_in` input 1: request present this cycle.
- `data_out` output 32: load data, or store data echoed for stores.
- `id_out` output 4: id of the completing request.
- `ready_out` output 1: one-cycle completion pulse.
- `stall_out` output 1: buffer full; requests ignored while high.

## Operation
- Backing store: 1024 x 32 words, not reset.
- Tag model: 16 lines x 4 words; offset `addr[3:2]`, index `addr[7:4]`, tag `addr[11:8]`; per-line valid bit plus 4-bit tag.
- Accept: `valid_in && !stall_out` at an edge. On accept:
  - Compute hit = line valid and tag equal.
  - On miss, the line is allocated (valid=1, tag written) for loads and stores alike.
  - Store: memory written at this edge; slot data = `data_in`.
  - Load: slot data = memory word read at this edge, which includes stores accepted at earlier edges.
  - Push a slot {id, data, cnt = (hit ? HIT_LAT : MISS_LAT) - 1} at the FIFO tail.
- `valid_in` while `stall_out` = 1: fully ignored; no memory write, no tag update, no slot.
- Countdown: every edge, each occupied slot with cnt > 0 decrements; cnt saturates at 0.
- Completion, strictly in order:
  - At an edge where the head slot has cnt == 0, pop it and register {`ready_out`=1, `id_out`, `data_out`}.
  - Otherwise `ready_out`=0, and `id_out`/`data_out` hold their last values.
- Younger slots that reach 0 wait behind the head. At most one pop per edge.
- Counting: occupancy `count` is 0..DEPTH. Accept and pop at the same edge leave `count` unchanged. Head/tail pointers wrap modulo DEPTH.
- `stall_out` = (`count` == DEPTH), decoded from registered state. It stays high during the edge that pops, so no accept occurs at that edge.

## Timing
- Reset (`rst` low, asynchronous):
  - `ready_out`=0, `id_out`=0, `data_out`=0, `stall_out`=0.
  - All slots invalid, count=0, pointers 0, all tag valid bits 0.
  - In-flight requests are discarded and never completed. Memory contents persist.
- Latency: accepted at edge E0 → `ready_out` high after edge E0+L, for exactly one cycle, where L = HIT_LAT or MISS_LAT. This holds when no older slot is pending; otherwise the response comes at max(E0+L, previous pop edge + 1).
- Throughput: one accept and one response per cycle.
- Full → not full: `stall_out` drops after the first pop edge. The next accept is at the edge after that.
- Simultaneous accept + pop at the same edge is legal when not full.

## Test plan
- Reset: hold `rst` low, then release → `ready_out`=0, `stall_out`=0, `id_out`=0, `data_out`=0. No `ready_out` pulse for 20 cycles with `valid_in`=0.
- Miss then hit in order:
  - Store addr 0x40, data 0xDEADBEEF, id 3 at E0 → `ready_out` after E6 with id 3, data 0xDEADBEEF.
  - Load addr 0x40, id 4 at E1 (hit, cnt reaches 0 at E2) → waits for the head, `ready_out` after E7 with id 4, data 0xDEADBEEF.
- Hit latency: after the line at 0x40 is warm, load 0x44 id 9 with the FIFO empty → `ready_out` exactly 2 edges later, single-cycle pulse.
- Full/stall:
  - Misses to 0x000, 0x010, 0x020, 0x030 at E0..E3 → `stall_out`=1 after E3.
  - `valid_in` store to 0x050 at E4 is ignored: memory unchanged, no response for it.
  - First pop at E6 → `stall_out`=0 after E6.
- Conflict miss: loads 0x000, 0x100, 0x000 (same index, tags 0/1/0) at an empty FIFO, spaced 10 cycles apart → each responds 6 edges after its accept.
- Reset mid-operation:
  - Two misses accepted, then `rst` low 1 cycle before either completes → outputs 0 immediately, and neither id ever appears.
  - A later load to the same address responds with MISS_LAT.
